uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte buffer and launch sequencer that sits directly upstream of the uart transmitter.
- Accepts bytes from the host side into a circular FIFO.
- Pops one byte at a time and drives the transmitter's tx_start/tx_data pair.
- Uses the transmitter's tx_busy to pace launches, so the host can burst-write several bytes without watching the serial line.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.
- BUSY_TIMEOUT, 4, cycles to wait after tx_start for tx_busy to rise before abandoning the launch.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- wr_en  input  1  host write strobe; one byte per cycle.
- wr_data  input  8  host byte.
- full  output  1  FIFO holds DEPTH bytes; writes are ignored.
- empty  output  1  FIFO holds 0 bytes.
- count  output  ADDR_W+1  bytes currently stored; excludes the byte in flight.
- tx_start  output  1  one-cycle launch pulse to the transmitter.
- tx_data  output  8  byte to the transmitter; stable from the tx_start cycle until the FSM returns to IDLE.
- tx_busy  input  1  transmitter busy flag.
- launch_err  output  1  sticky; set on busy timeout; cleared only by rst.

Behaviour:
- Reset (async, rst=1):
  - rd_ptr=wr_ptr=0, count=0, empty=1, full=0.
  - tx_start=0, tx_data=8'h00, launch_err=0, state=IDLE.
  - tx_start drops immediately on rst assertion, even mid-launch.
- Write path:
  - If wr_en && !full at a rising edge: mem[wr_ptr]<=wr_data, wr_ptr++ (wraps modulo DEPTH).
  - wr_en while full: byte dropped; no state change.
  - full and empty are derived from the registered count. A write while full is dropped even if a pop occurs in the same cycle.
- Count:
  - count = count + push - pop.
  - A simultaneous push and pop leaves count unchanged.
  - Never exceeds DEPTH; never underflows.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - IDLE: if !empty and tx_busy==0 -> START. On that edge: tx_data<=mem[rd_ptr], rd_ptr++, count--, tx_start<=1.
  - START (exactly 1 cycle): tx_start<=0 -> WAIT_BUSY; clear the timeout counter.
  - WAIT_BUSY:
    - tx_busy==1 -> WAIT_DONE.
    - Otherwise the counter increments; when it reaches BUSY_TIMEOUT, set launch_err -> IDLE. The byte is considered consumed and is not retried.
  - WAIT_DONE: tx_busy==0 -> IDLE.
- Latency:
  - A byte written at edge k into an empty FIFO with the FSM in IDLE gives tx_start high during the cycle after edge k+1.
  - Back-to-back bytes: the next tx_start occurs no earlier than 1 cycle after tx_busy falls.
- tx_busy already high in IDLE (transmitter driven by another source): the FSM stays in IDLE.
- Pointer wrap: rd_ptr and wr_ptr wrap independently. Occupancy is tracked only by count.

Optional Feature:
- Macro: UART_TX_FIFO_STATS_EN.
- Defined:
  - Adds output drop_cnt [15:0]: increments on each wr_en while full; saturates at 16'hFFFF; reset to 0.
  - Adds output tx_cnt [15:0]: increments on each tx_start pulse; wraps; reset to 0.
- Undefined: neither port nor its counters exist. All other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (2-bit localparams: IDLE=0, START=1, WAIT_BUSY=2, WAIT_DONE=3).
  - UART_DATA_W=8.
  - Default BUSY_TIMEOUT.
- One sub-module is natural: uart_sync_fifo, the storage array plus pointers/count/full/empty with push/pop ports.
- uart_tx_fifo instantiates uart_sync_fifo and holds the launch FSM and the error/stat logic.

Test Plan:
1. Reset then idle:
   - Stimulus: hold rst 2 cycles, release.
   - Required: empty=1, full=0, count=0, tx_start=0, tx_data=8'h00, launch_err=0.
2. Single byte:
   - Stimulus: write 8'hA5 at edge k; model tx_busy high 1 cycle after tx_start for 100 cycles.
   - Required: tx_start pulses exactly 1 cycle after edge k+1, with tx_data=8'hA5; FSM returns to IDLE; empty=1.
3. Burst and order:
   - Stimulus: write 8'h11, 8'h22, 8'h33 on consecutive cycles.
   - Required: count peaks at 2; three tx_start pulses with tx_data 8'h11, 8'h22, 8'h33 in order; each pulse comes after tx_busy falls from the previous byte.
4. Full and wrap:
   - Stimulus: DEPTH=4; hold tx_busy=1; write 5 bytes 8'h01..8'h05.
   - Required: full=1 after 4 accepted, 8'h05 dropped (drop_cnt=1 with UART_TX_FIFO_STATS_EN). Release busy; bytes 01..04 are sent. Then write 8'h06 and 8'h07; pointers wrap and they are sent in order.
5. Busy timeout:
   - Stimulus: write 8'h5A; tx_busy never rises.
   - Required: launch_err=1 exactly BUSY_TIMEOUT cycles after START exits; FSM in IDLE; count=0; the next byte still launches.
6. Reset mid-launch:
   - Stimulus: assert rst during WAIT_DONE with 2 bytes queued.
   - Required: all outputs take reset values asynchronously; the queued bytes are discarded; no tx_start after release until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer: data width, launch FSM encoding
// and the default transmitter busy timeout.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int BUSY_TIMEOUT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host write port plus transmitter launch port of uart_tx_fifo.
// UART_TX_FIFO_STATS_EN adds the drop_cnt/tx_cnt statistics signals.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    import uart_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);

    logic                   wr_en;
    logic [UART_DATA_W-1:0] wr_data;
    logic                   full;
    logic                   empty;
    logic [ADDR_W:0]        count;
    logic                   tx_start;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_busy;
    logic                   launch_err;
`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0]            drop_cnt;
    logic [15:0]            tx_cnt;

    modport master (output wr_en, wr_data, tx_busy,
                    input  full, empty, count, tx_start, tx_data, launch_err, drop_cnt, tx_cnt);
    modport slave  (input  wr_en, wr_data, tx_busy,
                    output full, empty, count, tx_start, tx_data, launch_err, drop_cnt, tx_cnt);
`else
    modport master (output wr_en, wr_data, tx_busy,
                    input  full, empty, count, tx_start, tx_data, launch_err);
    modport slave  (input  wr_en, wr_data, tx_busy,
                    output full, empty, count, tx_start, tx_data, launch_err);
`endif

endinterface

// File: rtl/uart_sync_fifo.sv
// Circular byte store with independent wrapping pointers; occupancy lives only in count,
// and full/empty are registered alongside it.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_req,
    input  logic                           pop_req,
    input  logic [UART_DATA_W-1:0]         wr_data,
    output logic [UART_DATA_W-1:0]         rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH):0]         count
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [UART_DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr_r;
    logic [ADDR_W-1:0]      rd_ptr_r;
    logic [ADDR_W:0]        count_r;
    logic [ADDR_W:0]        count_nx_s;
    logic                   full_r;
    logic                   empty_r;
    logic                   push_s;
    logic                   pop_s;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign push_s = push_req && !full_r;
    assign pop_s  = pop_req && !empty_r;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nx_s = count_r;
        if (push_s && !pop_s) begin
            count_nx_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nx_s = count_r - CNT_ONE;
        end else begin
            count_nx_s = count_r;
        end
    end

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nx_s;
            full_r  <= (count_nx_s == CNT_FULL);
            empty_r <= (count_nx_s == CNT_ZERO);
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter, paced by tx_busy.
// Optional UART_TX_FIFO_STATS_EN adds drop_cnt and tx_cnt statistics counters.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

    tx_state_e              state_r;
    tx_state_e              state_nx_s;
    logic [TMR_W-1:0]       timer_r;
    logic [TMR_W-1:0]       timer_nx_s;
    logic                   tx_start_r;
    logic                   tx_start_nx_s;
    logic [UART_DATA_W-1:0] tx_data_r;
    logic [UART_DATA_W-1:0] tx_data_nx_s;
    logic                   launch_err_r;
    logic                   launch_err_nx_s;
    logic                   pop_s;
    logic [UART_DATA_W-1:0] rd_data_s;
    logic                   full_s;
    logic                   empty_s;

    uart_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_req (bus.wr_en),
        .pop_req  (pop_s),
        .wr_data  (bus.wr_data),
        .rd_data  (rd_data_s),
        .full     (full_s),
        .empty    (empty_s),
        .count    (bus.count)
    );

    // Launch FSM next state; a byte popped here is consumed whether or not the launch succeeds.
    always_comb begin
        state_nx_s      = state_r;
        timer_nx_s      = timer_r;
        tx_start_nx_s   = 1'b0;
        tx_data_nx_s    = tx_data_r;
        launch_err_nx_s = launch_err_r;
        pop_s           = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s && !bus.tx_busy) begin
                    state_nx_s    = START;
                    tx_start_nx_s = 1'b1;
                    tx_data_nx_s  = rd_data_s;
                    pop_s         = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                state_nx_s = WAIT_BUSY;
                timer_nx_s = TMR_ZERO;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nx_s = WAIT_DONE;
                end else if (timer_r == TMR_LAST) begin
                    state_nx_s      = IDLE;
                    launch_err_nx_s = 1'b1;
                end else begin
                    timer_nx_s = timer_r + TMR_ONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WAIT_DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM and launch output registers; tx_start clears the instant rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            timer_r      <= TMR_ZERO;
            tx_start_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            launch_err_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            timer_r      <= timer_nx_s;
            tx_start_r   <= tx_start_nx_s;
            tx_data_r    <= tx_data_nx_s;
            launch_err_r <= launch_err_nx_s;
        end
    end

    assign bus.full       = full_s;
    assign bus.empty      = empty_s;
    assign bus.tx_start   = tx_start_r;
    assign bus.tx_data    = tx_data_r;
    assign bus.launch_err = launch_err_r;

`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0] drop_cnt_r;
    logic [15:0] tx_cnt_r;

    // Dropped-write counter saturates; launch counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r <= 16'h0000;
            tx_cnt_r   <= 16'h0000;
        end else begin
            if (bus.wr_en && full_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end
            if (tx_start_nx_s) begin
                tx_cnt_r <= tx_cnt_r + 16'h0001;
            end
        end
    end

    assign bus.drop_cnt = drop_cnt_r;
    assign bus.tx_cnt   = tx_cnt_r;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH=4, BUSY_TIMEOUT=4) with hand-computed expectations.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_tx_fifo_if #(.DEPTH(4)) bus ();

    uart_tx_fifo #(
        .DEPTH        (4),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Entered in the cycle where tx_start is high; acts as the transmitter until idle again.
    task automatic serve(input logic [7:0] exp_byte);
        check("tx_start_pulse", bus.tx_start, 1);
        check("tx_data", bus.tx_data, exp_byte);
        bus.tx_busy = 1'b1;
        tick();
        check("tx_start_one_cycle", bus.tx_start, 0);
        check("tx_data_stable", bus.tx_data, exp_byte);
        tick();
        tick();
        tick();
        check("no_start_while_busy", bus.tx_start, 0);
        bus.tx_busy = 1'b0;
        tick();
        check("no_start_on_busy_fall", bus.tx_start, 0);
        check("state_idle", dut.state_r, IDLE);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.tx_busy = 1'b0;

        // 1: reset then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_count", bus.count, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_launch_err", bus.launch_err, 0);

        // 2: single byte, latency edge k -> pulse after edge k+1
        write_byte(8'hA5);
        check("single_count", bus.count, 1);
        check("single_no_early_start", bus.tx_start, 0);
        tick();
        check("single_count_after_pop", bus.count, 0);
        serve(8'hA5);
        check("single_empty", bus.empty, 1);

        // 3: burst and order
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h11;
        tick();
        check("burst_count1", bus.count, 1);
        bus.wr_data = 8'h22;
        tick();
        check("burst_count2", bus.count, 1);
        check("burst_start11", bus.tx_start, 1);
        check("burst_data11", bus.tx_data, 8'h11);
        bus.wr_data = 8'h33;
        tick();
        bus.wr_en = 1'b0;
        check("burst_count_peak", bus.count, 2);
        check("burst_start_low", bus.tx_start, 0);
        bus.tx_busy = 1'b1;
        tick();
        tick();
        tick();
        bus.tx_busy = 1'b0;
        tick();
        check("burst_wait_after_fall", bus.tx_start, 0);
        tick();
        check("burst_count_22", bus.count, 1);
        serve(8'h22);
        tick();
        serve(8'h33);

        // 4: full, drop and pointer wrap (tx_busy held high keeps the FSM idle)
        bus.tx_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            write_byte(8'(i));
            check("fill_count", bus.count, (i > 4) ? 4 : i);
            check("fill_full", bus.full, (i >= 4) ? 1 : 0);
        end
        check("busy_idle_no_start", bus.tx_start, 0);
`ifdef UART_TX_FIFO_STATS_EN
        check("drop_cnt", bus.drop_cnt, 16'd1);
`endif
        bus.tx_busy = 1'b0;
        tick();
        check("drain_count", bus.count, 3);
        check("drain_not_full", bus.full, 0);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            serve(8'(i));
        end
        check("drain_empty", bus.empty, 1);
        write_byte(8'h06);
        write_byte(8'h07);
        serve(8'h06);
        tick();
        serve(8'h07);
`ifdef UART_TX_FIFO_STATS_EN
        check("tx_cnt", bus.tx_cnt, 16'd10);
`endif

        // 5: busy timeout
        write_byte(8'h5A);
        tick();
        check("to_start", bus.tx_start, 1);
        check("to_data", bus.tx_data, 8'h5A);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_err_not_yet", bus.launch_err, 0);
        end
        tick();
        check("to_err_set", bus.launch_err, 1);
        check("to_state_idle", dut.state_r, IDLE);
        check("to_count", bus.count, 0);
        write_byte(8'h5B);
        tick();
        serve(8'h5B);
        check("to_err_sticky", bus.launch_err, 1);

        // 6: reset during WAIT_DONE with two bytes queued
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hC1;
        tick();
        bus.wr_data = 8'hC2;
        tick();
        bus.wr_data = 8'hC3;
        tick();
        bus.wr_en = 1'b0;
        bus.tx_busy = 1'b1;
        tick();
        check("mid_state_wait_done", dut.state_r, WAIT_DONE);
        check("mid_count", bus.count, 2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", bus.count, 0);
        check("arst_empty", bus.empty, 1);
        check("arst_tx_data", bus.tx_data, 8'h00);
        check("arst_launch_err", bus.launch_err, 0);
        check("arst_state", dut.state_r, IDLE);
        bus.tx_busy = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_start", bus.tx_start, 0);
        end

        // tx_start must drop asynchronously when rst hits mid-pulse
        write_byte(8'hD1);
        tick();
        check("d1_start", bus.tx_start, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_tx_start", bus.tx_start, 0);
        check("arst_tx_data2", bus.tx_data, 8'h00);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst2_no_start", bus.tx_start, 0);
        end
        write_byte(8'hE1);
        tick();
        serve(8'hE1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
